handshake_protocol_monitor: RTL
===============================

Name: handshake_protocol_monitor

Overview:
Parametrised, synthesisable successor to the per-design bound RTL monitors. It watches NUM_CH valid/ready/data channels and checks three rules on each one: valid stability, data stability and stall timeout. It counts completed transfers per channel and latches sticky violation flags. It is bound alongside the design under test, and it exposes registered status so that both simulation assertions and on-chip debug can observe it.

Parameters:
NUM_CH, 3, number of monitored handshake channels (1..16)
DATA_W, 5, payload width per channel
CNT_W, 16, width of each per-channel transfer counter
TIMEOUT, 64, stall length in cycles (valid&&!ready) that raises a timeout violation; TIMEOUT >= 2

Ports:
CLK  input  1  clock; all state updates on posedge
RESETN  input  1  synchronous reset, active-low
enable  input  1  checking and counting active when 1
clear  input  1  synchronous clear of counters, flags and first-error capture
valid  input  NUM_CH  per-channel valid
ready  input  NUM_CH  per-channel ready
data  input  NUM_CH*DATA_W  per-channel payload; channel i occupies bits [i*DATA_W +: DATA_W]
xfer_count  output  NUM_CH*CNT_W  per-channel completed-transfer count, packed the same way as data
err_flags  output  NUM_CH*3  sticky per-channel flags; bit0 DROP, bit1 DATA, bit2 TIMEOUT
err_any  output  1  OR of all err_flags
first_err_valid  output  1  a first error has been captured
first_err_ch  output  $clog2(NUM_CH) (min 1)  channel of the first error
first_err_code  output  3  one-hot code of the first error

Behaviour:
- Reset: when RESETN==0 at a posedge, all outputs and all internal state go to 0, and every channel returns to IDLE. Reset dominates clear and enable.
- clear==1 (with RESETN==1) has the same effect as reset on the next edge. It takes priority over any event in the same cycle; that cycle is neither counted nor checked.
- enable==0: every channel FSM is forced to IDLE, stall counters go to 0, and no counting or flagging happens. Outputs hold their values.
- Per-channel FSM states are IDLE and STALL.
  - IDLE, valid&&ready: transfer. Counter increments; stay in IDLE.
  - IDLE, valid&&!ready: capture data into a hold register, set stall_cnt=1, go to STALL.
  - IDLE, !valid: no action.
  - STALL, !valid: set the DROP flag and go to IDLE. Nothing is counted.
  - STALL, valid && data != held: set the DATA flag. The held value is not updated, so it keeps comparing against the first captured value.
  - STALL, valid&&ready: transfer counted; go to IDLE. This applies even when DATA is flagged in the same cycle; both actions occur.
  - STALL, valid&&!ready: stall_cnt increments, saturating at TIMEOUT. The TIMEOUT flag is set on the cycle in which stall_cnt becomes TIMEOUT, i.e. the TIMEOUT-th consecutive stalled cycle. It fires at most once per stall.
- Latency: flags, counters and first-error outputs are registered. They become visible one cycle after the violating or transferring cycle.
- Counters wrap modulo 2^CNT_W, with no saturation and no overflow flag.
- Flags are sticky until reset or clear. A flag that is already set being set again has no effect.
- First-error capture:
  - Loads on the first cycle in which any new violation is detected while first_err_valid==0.
  - Across channels, the lowest channel index wins a tie.
  - Within a channel, first_err_code holds all codes detected that cycle (e.g. DATA|TIMEOUT = 3'b110).
  - The capture is frozen until clear or reset.
- Channels are fully independent. Simultaneous events on different channels are all processed in the same cycle.

Decomposition:
- Package handshake_monitor_pkg holds:
  - the channel state enum (IDLE, STALL)
  - error-bit constants ERR_DROP=0, ERR_DATA=1, ERR_TIMEOUT=2
  - the error-code width constant (3)
- Sub-module handshake_channel_checker is instantiated NUM_CH times by generate. It owns the FSM, hold register, stall counter, transfer counter and sticky flags for one channel, and outputs a per-cycle new_err[2:0] pulse.
- The top level does packing, err_any, and lowest-index first-error priority.

Test Plan:
- Reset and clean transfers: RESETN low 2 cycles, then channel 0 gets 5 back-to-back valid&&ready -> xfer_count[0]=5, err_flags all 0, err_any=0, first_err_valid=0.
- Valid drop: channel 1 has valid=1, ready=0 for 3 cycles, then valid=0 -> next cycle err_flags[1]=3'b001, first_err_ch=1, first_err_code=3'b001, xfer_count[1]=0.
- Data change with accept: channel 2 stalls with data=5'h0A, then data=5'h0B together with ready=1 -> err_flags[2]=3'b010, xfer_count[2]=1, channel back in IDLE.
- Timeout: TIMEOUT=4, channel 0 stalled for 6 cycles, then accepted -> TIMEOUT flag set one cycle after the 4th stalled cycle and set once only; xfer_count[0]=1.
- Simultaneous errors and priority: channels 2 and 1 drop valid in the same cycle -> first_err_ch=1, err_flags[1] and err_flags[2] both 3'b001. A later error on channel 0 leaves the first-error capture unchanged.
- Clear and reset mid-stall, plus wrap:
  - clear asserted during a channel 0 stall -> all outputs 0 next cycle and channel 0 in IDLE; valid low afterwards raises no DROP.
  - CNT_W=4, 17 transfers -> xfer_count=1.
  - RESETN low while clear=1 -> same all-zero result.

Source files
------------

// File: rtl/handshake_protocol_monitor_pkg.sv
// Shared types and constants for the valid/ready handshake monitor.
package handshake_monitor_pkg;
  typedef enum logic {IDLE = 1'b0, STALL = 1'b1} ch_state_t;

  localparam int ERR_W       = 3;
  localparam int ERR_DROP    = 0;
  localparam int ERR_DATA    = 1;
  localparam int ERR_TIMEOUT = 2;
endpackage

// File: rtl/handshake_channel_checker.sv
// One channel of the handshake monitor: stability/timeout checks, transfer count, sticky flags.
module handshake_channel_checker
  import handshake_monitor_pkg::*;
#(
  parameter int DATA_W  = 5,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  input  logic              clear,
  input  logic              valid,
  input  logic              ready,
  input  logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  count,
  output logic [ERR_W-1:0]  flags,
  output logic [ERR_W-1:0]  new_err
);
  localparam int SC_W = $clog2(TIMEOUT + 1);
  localparam logic [SC_W-1:0] SC_TO  = SC_W'(TIMEOUT);
  localparam logic [SC_W-1:0] SC_TM1 = SC_W'(TIMEOUT - 1);

  ch_state_t         state;
  logic [DATA_W-1:0] hold;
  logic [SC_W-1:0]   stall_cnt;

  // Detections are only meaningful while stalled; gated so clear/disable cycles never report.
  always_comb begin
    new_err = '0;
    if (enable && !clear && state == STALL) begin
      if (!valid) begin
        new_err[ERR_DROP] = 1'b1;
      end else begin
        if (data != hold) new_err[ERR_DATA] = 1'b1;
        if (!ready && stall_cnt == SC_TM1) new_err[ERR_TIMEOUT] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      state     <= IDLE;
      hold      <= '0;
      stall_cnt <= '0;
      count     <= '0;
      flags     <= '0;
    end else if (!enable) begin
      state     <= IDLE;
      stall_cnt <= '0;
    end else begin
      flags <= flags | new_err;
      case (state)
        IDLE: begin
          if (valid && ready) begin
            count <= count + CNT_W'(1);
          end else if (valid) begin
            hold      <= data;
            stall_cnt <= SC_W'(1);
            state     <= STALL;
          end
        end
        STALL: begin
          if (!valid) begin
            state     <= IDLE;
            stall_cnt <= '0;
          end else if (ready) begin
            count     <= count + CNT_W'(1);
            state     <= IDLE;
            stall_cnt <= '0;
          end else if (stall_cnt != SC_TO) begin
            stall_cnt <= stall_cnt + SC_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/handshake_protocol_monitor.sv
// Multi-channel handshake monitor: per-channel checkers plus lowest-index first-error capture.
module handshake_protocol_monitor
  import handshake_monitor_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int DATA_W  = 5,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     CLK,
  input  logic                     RESETN,
  input  logic                     enable,
  input  logic                     clear,
  input  logic [NUM_CH-1:0]        valid,
  input  logic [NUM_CH-1:0]        ready,
  input  logic [NUM_CH*DATA_W-1:0] data,
  output logic [NUM_CH*CNT_W-1:0]  xfer_count,
  output logic [NUM_CH*ERR_W-1:0]  err_flags,
  output logic                     err_any,
  output logic                     first_err_valid,
  output logic [CH_W-1:0]          first_err_ch,
  output logic [ERR_W-1:0]         first_err_code
);
  logic [NUM_CH-1:0][ERR_W-1:0] ch_new;
  logic                         hit;
  logic [CH_W-1:0]              hit_ch;
  logic [ERR_W-1:0]             hit_code;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    handshake_channel_checker #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W),
      .TIMEOUT(TIMEOUT)
    ) u_chk (
      .clk    (CLK),
      .resetn (RESETN),
      .enable (enable),
      .clear  (clear),
      .valid  (valid[g]),
      .ready  (ready[g]),
      .data   (data[g*DATA_W +: DATA_W]),
      .count  (xfer_count[g*CNT_W +: CNT_W]),
      .flags  (err_flags[g*ERR_W +: ERR_W]),
      .new_err(ch_new[g])
    );
  end

  assign err_any = |err_flags;

  // Scan high to low so the lowest-index channel with a detection wins.
  always_comb begin
    hit      = 1'b0;
    hit_ch   = '0;
    hit_code = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (|ch_new[i]) begin
        hit      = 1'b1;
        hit_ch   = CH_W'(i);
        hit_code = ch_new[i];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN || clear) begin
      first_err_valid <= 1'b0;
      first_err_ch    <= '0;
      first_err_code  <= '0;
    end else if (hit && !first_err_valid) begin
      first_err_valid <= 1'b1;
      first_err_ch    <= hit_ch;
      first_err_code  <= hit_code;
    end
  end
endmodule
